// File: rtl/sync_fifo_w128_d15.sv
// Single-clock FIFO, 15 x 128-bit words, with handshake pulses and occupancy counts.
// Latency: a read accepted at edge N presents dout/valid in cycle N+1; a write is readable one edge after it lands.
// Backpressure: writes while full are dropped and flagged by overflow; reads while empty are dropped and flagged by underflow.
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   din, wr_en           - write data and request
//   rd_en                - read request
//   dout, valid          - registered read data and its one-cycle qualifier
//   full, empty          - occupancy == 15 / occupancy == 0
//   wr_ack, overflow     - previous-cycle write accepted / rejected
//   underflow            - previous-cycle read rejected
//   rd_data_count,
//   wr_data_count        - current occupancy (identical values)
module sync_fifo_w128_d15 #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              wr_ack,
  output logic              overflow,
  output logic              valid,
  output logic              underflow,
  output logic [CNT_W-1:0]  rd_data_count,
  output logic [CNT_W-1:0]  wr_data_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CNT_W-1:0]  count;
  logic              wr_acc;
  logic              rd_acc;

  // One slot is sacrificed so occupancy fits in ADDR_W bits without wrapping.
  assign full  = (count == CNT_W'(DEPTH - 1));
  assign empty = (count == '0);

  // Decisions use the pre-edge flags, so a simultaneous read never frees
  // room for a write in the same cycle (and vice versa).
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  assign rd_data_count = count;
  assign wr_data_count = count;

  // Storage is not reset: clearing the pointers is what discards old data.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      dout      <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      valid     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_acc;
      overflow  <= wr_en & full;
      valid     <= rd_acc;
      underflow <= rd_en & empty;

      if (wr_acc) begin
        wptr <= wptr + ADDR_W'(1);
      end

      // rptr never equals wptr while non-empty, so this slot is never the
      // one being written on the same edge.
      if (rd_acc) begin
        dout <= mem[rptr];
        rptr <= rptr + ADDR_W'(1);
      end

      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_w128_d15.sv
module tb_sync_fifo_w128_d15;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] din = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          full, empty, wr_ack, overflow, valid, underflow;
  logic [3:0]    rd_data_count, wr_data_count;

  sync_fifo_w128_d15 dut (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty), .wr_ack(wr_ack),
    .overflow(overflow), .valid(valid), .underflow(underflow),
    .rd_data_count(rd_data_count), .wr_data_count(wr_data_count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the pulses it implies.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_wack, m_ovf, m_vld, m_unf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic logic [13:0] exp_flags();
    logic [3:0] n;
    n = 4'(q.size());
    return {q.size() == 15, q.size() == 0, m_wack, m_ovf, m_vld, m_unf, n, n};
  endfunction

  function automatic logic [13:0] dut_flags();
    return {full, empty, wr_ack, overflow, valid, underflow, rd_data_count, wr_data_count};
  endfunction

  function automatic void model_clear();
    q.delete();
    m_dout = '0;
    m_wack = 1'b0; m_ovf = 1'b0; m_vld = 1'b0; m_unf = 1'b0;
  endfunction

  // Drive one cycle of stimulus, advance the model, return #1 after the edge.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
    bit was_full, was_empty;
    @(negedge clk);
    wr_en = w; rd_en = r; din = d;
    @(posedge clk);
    was_full  = (q.size() == 15);
    was_empty = (q.size() == 0);
    m_wack = w && !was_full;
    m_ovf  = w && was_full;
    m_vld  = r && !was_empty;
    m_unf  = r && was_empty;
    if (m_vld) m_dout = q.pop_front();
    if (m_wack) q.push_back(d);
    cyc++;
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if (dut_flags() !== exp_flags() || dout !== m_dout) begin
      n_fail++;
      $display("FAIL reset_async flags got %b want %b dout got %h want %h",
               dut_flags(), exp_flags(), dout, m_dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, '0);
      n_checks++;
      if (dut_flags() !== exp_flags() || dout !== m_dout) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d flags got %b want %b dout got %h want %h",
                 cyc, dut_flags(), exp_flags(), dout, m_dout);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 1'b0, DW'(i));
      n_checks++;
      if (dut_flags() !== exp_flags()) begin
        n_fail++;
        $display("FAIL fill i=%0d flags got %b want %b", i, dut_flags(), exp_flags());
      end
    end
    n_checks++;
    if (full !== 1'b1 || rd_data_count !== 4'd15) begin
      n_fail++;
      $display("FAIL fill_full full got %b want 1 count got %0d want 15", full, rd_data_count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, DW'(15 + i));
      n_checks++;
      if (dut_flags() !== exp_flags() || overflow !== 1'b1 || wr_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL overflow i=%0d flags got %b want %b", i, dut_flags(), exp_flags());
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, '0);
      n_checks++;
      if (dut_flags() !== exp_flags() || dout !== m_dout) begin
        n_fail++;
        $display("FAIL drain i=%0d flags got %b want %b dout got %h want %h",
                 i, dut_flags(), exp_flags(), dout, m_dout);
      end
    end
    n_checks++;
    if (dout !== DW'(14) || underflow !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_underflow dout got %h want e underflow got %b valid got %b",
               dout, underflow, valid);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] next_din = '0;
    logic [DW-1:0] next_rd  = '0;
    int reads = 0;
    int budget = 0;
    while (reads < 110 && budget < 2000) begin
      cycle(1'b1, q.size() == 15, next_din);
      budget++;
      if (m_wack) next_din++;
      n_checks++;
      if (dut_flags() !== exp_flags() || (valid && dout !== next_rd)) begin
        n_fail++;
        $display("FAIL wrap cyc=%0d flags got %b want %b dout got %h want %h",
                 cyc, dut_flags(), exp_flags(), dout, next_rd);
      end
      if (m_vld) begin
        next_rd++;
        reads++;
      end
    end
    n_checks++;
    if (reads < 110) begin
      n_fail++;
      $display("FAIL wrap_timeout reads got %0d want 110", reads);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
            {$urandom, $urandom, $urandom, $urandom});
      n_checks++;
      if (dut_flags() !== exp_flags() || dout !== m_dout) begin
        n_fail++;
        $display("FAIL random cyc=%0d flags got %b want %b dout got %h want %h",
                 cyc, dut_flags(), exp_flags(), dout, m_dout);
      end
    end
  endtask

  task automatic test_corners();
    pulse_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, DW'(100 + i));
    cycle(1'b1, 1'b1, DW'(200));
    n_checks++;
    if (rd_data_count !== 4'd7 || wr_ack !== 1'b1 || valid !== 1'b1 || dout !== DW'(100)) begin
      n_fail++;
      $display("FAIL simul_mid count got %0d want 7 dout got %h want 64", rd_data_count, dout);
    end
    while (q.size() < 15) cycle(1'b1, 1'b0, DW'($urandom));
    cycle(1'b1, 1'b1, DW'(300));
    n_checks++;
    if (dut_flags() !== exp_flags() || rd_data_count !== 4'd14 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_full flags got %b want %b", dut_flags(), exp_flags());
    end
    while (q.size() > 0) cycle(1'b0, 1'b1, '0);
    cycle(1'b1, 1'b1, DW'(400));
    n_checks++;
    if (dut_flags() !== exp_flags() || rd_data_count !== 4'd1 || underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_empty flags got %b want %b", dut_flags(), exp_flags());
    end
    while (q.size() < 9) cycle(1'b1, 1'b0, DW'($urandom));
    pulse_reset();
    n_checks++;
    if (empty !== 1'b1 || rd_data_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_midop empty got %b want 1 count got %0d want 0", empty, rd_data_count);
    end
    cycle(1'b1, 1'b0, DW'(8'hA5));
    cycle(1'b0, 1'b1, '0);
    n_checks++;
    if (dout !== DW'(8'hA5) || valid !== 1'b1 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_read dout got %h want a5 valid got %b", dout, valid);
    end
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_random();
    test_corners();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_w128_d15.md
Name: sync_fifo_w128_d15

Overview:
- Single-clock first-in-first-out buffer.
- Capacity is 15 words of 128 bits.
- Provides full/empty flags, per-operation handshake pulses (write acknowledge, overflow, read valid, underflow) and occupancy counts.
- Decouples a producer and a consumer in the same clock domain; replaces the generated FIFO core used in the streaming datapath.

Parameters:
- DATA_W, 128, width of each stored word.
- ADDR_W, 4, pointer width; storage has 2**ADDR_W = 16 slots, usable depth is 2**ADDR_W-1 = 15.
- CNT_W, 4, width of the occupancy count outputs; must equal ADDR_W.

Ports:
- clk, in, 1, single clock; all state changes on its rising edge.
- rst_n, in, 1, asynchronous active-low reset; assertion takes effect immediately, release is synchronous to clk.
- din, in, DATA_W, write data.
- wr_en, in, 1, write request.
- rd_en, in, 1, read request.
- dout, out, DATA_W, read data, registered.
- full, out, 1, occupancy == 15.
- empty, out, 1, occupancy == 0.
- wr_ack, out, 1, one-cycle pulse: the previous-cycle write was accepted.
- overflow, out, 1, one-cycle pulse: the previous-cycle write was rejected.
- valid, out, 1, one-cycle pulse: dout holds a newly read word.
- underflow, out, 1, one-cycle pulse: the previous-cycle read was rejected.
- rd_data_count, out, CNT_W, current occupancy, 0..15.
- wr_data_count, out, CNT_W, current occupancy, 0..15; identical to rd_data_count.

Behaviour:
- Reset (rst_n=0):
  - Pointers and count are cleared to 0.
  - empty=1, full=0; wr_ack, overflow, valid and underflow are 0; dout=0.
  - Stored data is discarded, including when reset is applied mid-operation.
- Storage: 16-entry array indexed by 4-bit write and read pointers that wrap 15->0.
  - Occupancy is a 4-bit counter, or pointer difference modulo 16.
  - Never more than 15 entries; the counts never wrap.
- Write accept = wr_en & ~full, where full is the value before the edge.
  - On accept: mem[wptr] <= din, wptr++, and wr_ack=1 for the next cycle.
  - wr_en & full: no state change, overflow=1 for the next cycle.
  - wr_ack and overflow are never high together; both are 0 when wr_en=0.
- Read accept = rd_en & ~empty, where empty is the value before the edge.
  - On accept: dout <= mem[rptr], rptr++, and valid=1 for the next cycle.
  - rd_en & empty: underflow=1 for the next cycle; dout holds its last value.
  - valid=0 when no read is accepted; dout is held, not cleared.
- Read latency: rd_en sampled at edge N gives dout/valid during cycle N+1.
- Write-to-read latency: a word written at edge N sets empty=0 after edge N and can be read at edge N+1.
- Count update per edge: +1 write-only accept, -1 read-only accept, unchanged for both or neither.
- full, empty and both counts are registered or derived from registered state; all change only on clock edges or reset.
- Simultaneous wr_en & rd_en:
  - When 0 < occupancy < 15: both are accepted and the count is unchanged.
  - When full: the read is accepted, the write is rejected with overflow; the count becomes 14.
  - When empty: the write is accepted, the read is rejected with underflow; the count becomes 1.
- Ordering: words exit in exact write order across pointer wrap-around.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then idle:
  - Assert rst_n=0 mid-cycle with no clock edge -> empty=1, full=0, counts=0, all pulses 0, dout=0 immediately.
  - Release -> outputs remain in that state with no traffic.
- Fill:
  - Write din=0..14 on 15 consecutive cycles -> wr_ack=1 each following cycle.
  - Counts step 1..15; full=1 after the 15th edge; empty=0 after the first.
- Overflow: with the FIFO full, hold wr_en for 2 more cycles with din=15,16 -> overflow=1 for 2 cycles, wr_ack=0, count stays 15, contents unchanged.
- Drain:
  - rd_en for 15 cycles -> dout=0..14 in order with valid=1 each cycle.
  - full drops after the first read; empty=1 and count=0 after the 15th.
  - A 16th read gives underflow=1, valid=0, dout holds 14.
- Producer/consumer wrap:
  - Writer increments din only on wr_ack; reader asserts rd_en when full.
  - Over 100+ words (>6 pointer wraps), the read sequence is gap-free 0,1,2,… with no duplicates.
  - Simultaneous rd/wr at count 7 keeps count 7.
- Corner/reset mid-op:
  - Simultaneous rd/wr when full -> count 14 plus overflow; when empty -> count 1 plus underflow.
  - rst_n pulse with count 9 -> empty=1, count 0.
  - Next write of 0xA5 is read back as 0xA5.
